// File: rtl/i2c_fifo.sv
// i2c_fifo: TX (10-bit) and RX (8-bit) first-word-fall-through FIFOs between register block and I2C bus controller
// Event pulses are registered from the current/next occupancy of each buffer.
module i2c_fifo_buf #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         srstn,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdat,
    input  logic         i_rd,
    output logic [4:0]   o_ocy,
    output logic [4:0]   o_nxt,
    output logic [W-1:0] o_dat,
    output logic         o_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] FULL = 5'(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [4:0]    r_ocy;
    logic          w_rd;
    logic          w_wr;
    assign w_rd  = srstn && i_rd && r_ocy != 5'd0;
    // a full buffer still takes a push when a pop frees the slot in the same cycle
    assign w_wr  = srstn && i_wr && (r_ocy != FULL || w_rd);
    assign o_ovf = srstn && i_wr && !w_wr;
    assign o_nxt = (w_wr && !w_rd) ? r_ocy + 5'd1 : (w_rd && !w_wr) ? r_ocy - 5'd1 : r_ocy;
    assign o_ocy = r_ocy;
    assign o_dat = (r_ocy == 5'd0) ? '0 : r_mem[r_rp];
    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wp] <= i_wdat;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ocy <= '0;
        end else if (!srstn) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ocy <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            r_ocy <= o_nxt;
        end
    end
endmodule

module i2c_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       srstn,
    input  logic       tx_fifo_wr,
    input  logic [9:0] tx_fifo_wdat,
    output logic [4:0] tx_fifo_ocy,
    output logic       tx_vld,
    output logic [9:0] tx_dat,
    input  logic       tx_rd,
    input  logic       rx_wr,
    input  logic [7:0] rx_wdat,
    input  logic       rx_fifo_rd,
    output logic [7:0] rx_fifo_rdat,
    output logic [4:0] rx_fifo_ocy,
    input  logic [4:0] rx_fifo_pirq,
    output logic [5:0] fifo_irq
);
    localparam logic [4:0] FULL = 5'(DEPTH);
    localparam logic [4:0] HALF = 5'(DEPTH / 2);
    logic [4:0] w_tx_nxt;
    logic [4:0] w_rx_nxt;
    logic       w_tx_ovf;
    logic       w_rx_ovf;
    logic [5:0] w_irq;
    logic [5:0] r_irq;
    i2c_fifo_buf #(.DEPTH(DEPTH), .W(10)) u_tx (
        .clk(clk), .rstn(rstn), .srstn(srstn),
        .i_wr(tx_fifo_wr), .i_wdat(tx_fifo_wdat), .i_rd(tx_rd),
        .o_ocy(tx_fifo_ocy), .o_nxt(w_tx_nxt), .o_dat(tx_dat), .o_ovf(w_tx_ovf)
    );
    i2c_fifo_buf #(.DEPTH(DEPTH), .W(8)) u_rx (
        .clk(clk), .rstn(rstn), .srstn(srstn),
        .i_wr(rx_wr), .i_wdat(rx_wdat), .i_rd(rx_fifo_rd),
        .o_ocy(rx_fifo_ocy), .o_nxt(w_rx_nxt), .o_dat(rx_fifo_rdat), .o_ovf(w_rx_ovf)
    );
    assign tx_vld = tx_fifo_ocy != 5'd0;
    // threshold compared at 6 bits so pirq=31 (target 32) can never match
    assign w_irq = {
        w_rx_ovf,
        w_tx_ovf,
        w_rx_nxt != rx_fifo_ocy && {1'b0, w_rx_nxt} == {1'b0, rx_fifo_pirq} + 6'd1,
        rx_fifo_ocy == FULL - 5'd1 && w_rx_nxt == FULL,
        tx_fifo_ocy == HALF + 5'd1 && w_tx_nxt == HALF,
        tx_fifo_ocy == 5'd1 && w_tx_nxt == 5'd0
    };
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) r_irq <= '0;
        else r_irq <= srstn ? w_irq : 6'h00;
    assign fifo_irq = r_irq;
endmodule

// File: tb/tb_i2c_fifo.sv
// tb_i2c_fifo: randomized checks of i2c_fifo against a queue-based reference model
module tb_i2c_fifo;
    localparam int D = 16;
    logic       clk = 0;
    logic       rstn = 0;
    logic       srstn = 1;
    logic       tx_fifo_wr = 0;
    logic [9:0] tx_fifo_wdat = 0;
    logic [4:0] tx_fifo_ocy;
    logic       tx_vld;
    logic [9:0] tx_dat;
    logic       tx_rd = 0;
    logic       rx_wr = 0;
    logic [7:0] rx_wdat = 0;
    logic       rx_fifo_rd = 0;
    logic [7:0] rx_fifo_rdat;
    logic [4:0] rx_fifo_ocy;
    logic [4:0] rx_fifo_pirq = 5'd31;
    logic [5:0] fifo_irq;
    int checks = 0;
    int errors = 0;
    logic [9:0] tq[$];
    logic [7:0] rq[$];
    logic [5:0] e_irq = 0;
    logic [34:0] obs;

    i2c_fifo #(.DEPTH(D)) dut (
        .clk(clk), .rstn(rstn), .srstn(srstn),
        .tx_fifo_wr(tx_fifo_wr), .tx_fifo_wdat(tx_fifo_wdat), .tx_fifo_ocy(tx_fifo_ocy),
        .tx_vld(tx_vld), .tx_dat(tx_dat), .tx_rd(tx_rd),
        .rx_wr(rx_wr), .rx_wdat(rx_wdat), .rx_fifo_rd(rx_fifo_rd),
        .rx_fifo_rdat(rx_fifo_rdat), .rx_fifo_ocy(rx_fifo_ocy),
        .rx_fifo_pirq(rx_fifo_pirq), .fifo_irq(fifo_irq)
    );

    always #5 clk = ~clk;
    assign obs = {tx_fifo_ocy, tx_vld, tx_dat, rx_fifo_ocy, rx_fifo_rdat, fifo_irq};

    function automatic logic [34:0] expv();
        return {5'(tq.size()), tq.size() != 0, tq.size() != 0 ? tq[0] : 10'h0,
                5'(rq.size()), rq.size() != 0 ? rq[0] : 8'h0, e_irq};
    endfunction

    // one clock: drive, let the edge happen, advance the model, settle
    task automatic cyc(input logic twr, input logic [9:0] twd, input logic trd,
                       input logic rwr, input logic [7:0] rwd, input logic rrd);
        int tp, rp;
        bit tpop, tpush, rpop, rpush;
        tx_fifo_wr = twr; tx_fifo_wdat = twd; tx_rd = trd;
        rx_wr = rwr; rx_wdat = rwd; rx_fifo_rd = rrd;
        @(posedge clk);
        if (!srstn) begin
            tq.delete(); rq.delete(); e_irq = 0;
        end else begin
            tp = tq.size(); rp = rq.size();
            tpop = trd && tp > 0; tpush = twr && (tp < D || tpop);
            rpop = rrd && rp > 0; rpush = rwr && (rp < D || rpop);
            if (tpop) void'(tq.pop_front());
            if (tpush) tq.push_back(twd);
            if (rpop) void'(rq.pop_front());
            if (rpush) rq.push_back(rwd);
            e_irq = {rwr && !rpush, twr && !tpush,
                     rq.size() != rp && rq.size() == int'(rx_fifo_pirq) + 1,
                     rp == D - 1 && rq.size() == D,
                     tp == D / 2 + 1 && tq.size() == D / 2,
                     tp == 1 && tq.size() == 0};
        end
        #1;
        tx_fifo_wr = 0; tx_rd = 0; rx_wr = 0; rx_fifo_rd = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (obs !== 35'h0) begin errors++; $display("FAIL reset_async obs=%h exp=0", obs); end
        @(negedge clk); rstn = 1;
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== expv()) begin errors++; $display("FAIL reset_idle obs=%h exp=%h", obs, expv()); end
    endtask

    task automatic test_tx_basic();
        int pulses = 0;
        cyc(1, 10'h3A5, 0, 0, 0, 0);
        cyc(1, 10'h012, 0, 0, 0, 0);
        checks++;
        if (tx_dat !== 10'h3A5 || tx_fifo_ocy !== 5'd2) begin
            errors++; $display("FAIL tx_head2 dat=%h ocy=%0d exp=3a5/2", tx_dat, tx_fifo_ocy);
        end
        cyc(0, 0, 1, 0, 0, 0);
        checks++;
        if (obs !== expv() || tx_dat !== 10'h012) begin errors++; $display("FAIL tx_pop1 obs=%h exp=%h", obs, expv()); end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, i == 0, 0, 0, 0);
            pulses += int'(fifo_irq[0]);
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL tx_drain%0d obs=%h exp=%h", i, obs, expv()); end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL tx_empty_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_tx_overflow();
        for (int i = 0; i < D + 2; i++) begin
            cyc(1, 10'($urandom), 0, 0, 0, 0);
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL tx_fill%0d obs=%h exp=%h", i, obs, expv()); end
        end
        checks++;
        if (fifo_irq[4] !== 1'b1 || tx_fifo_ocy !== 5'd16) begin
            errors++; $display("FAIL tx_ovf irq=%b ocy=%0d exp=1/16", fifo_irq[4], tx_fifo_ocy);
        end
        cyc(1, 10'h2C7, 1, 0, 0, 0);
        checks++;
        if (obs !== expv() || fifo_irq[4] !== 1'b0) begin errors++; $display("FAIL tx_full_pushpop obs=%h exp=%h", obs, expv()); end
        for (int i = 0; i < D + 1; i++) begin
            cyc(0, 0, 1, 0, 0, 0);
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL tx_unload%0d obs=%h exp=%h", i, obs, expv()); end
        end
    endtask

    task automatic test_rx_threshold();
        rx_fifo_pirq = 5'd3;
        for (int i = 0; i < D + 2; i++) begin
            cyc(0, 0, 0, 1, 8'($urandom), 0);
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL rx_fill%0d obs=%h exp=%h", i, obs, expv()); end
            if (i == 3) begin
                checks++;
                if (fifo_irq[3] !== 1'b1) begin errors++; $display("FAIL rx_thresh irq3=%b exp=1", fifo_irq[3]); end
            end
        end
        for (int i = 0; i < D + 1; i++) begin
            cyc(0, 0, 0, 0, 0, 1);
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL rx_unload%0d obs=%h exp=%h", i, obs, expv()); end
        end
        cyc(0, 0, 0, 1, 8'h5C, 0);
        checks++;
        if (rx_fifo_rdat !== 8'h5C || obs !== expv()) begin errors++; $display("FAIL rx_after_empty_pop obs=%h exp=%h", obs, expv()); end
        cyc(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rx_fifo_pirq = 5'($urandom_range(0, 31));
            cyc($urandom_range(0, 2) != 0, 10'($urandom), $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1);
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL rand%0d obs=%h exp=%h", i, obs, expv()); end
        end
    endtask

    task automatic test_soft_reset();
        while (tq.size() > 0 || rq.size() > 0) cyc(0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 10'($urandom), 0, 1, 8'($urandom), 0);
        srstn = 0;
        cyc(1, 10'h155, 1, 1, 8'hAA, 1);
        srstn = 1;
        checks++;
        if (obs !== 35'h0 || obs !== expv()) begin errors++; $display("FAIL srst obs=%h exp=0", obs); end
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== expv()) begin errors++; $display("FAIL srst_after obs=%h exp=%h", obs, expv()); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cyc(1, 10'($urandom), 0, 1, 8'($urandom), 0);
        #2 rstn = 0;
        #1;
        tq.delete(); rq.delete(); e_irq = 0;
        checks++;
        if (obs !== 35'h0) begin errors++; $display("FAIL arst obs=%h exp=0", obs); end
        @(negedge clk); rstn = 1;
        cyc(1, 10'h3FF, 0, 1, 8'h81, 0);
        cyc(0, 0, 1, 0, 0, 1);
        checks++;
        if (obs !== expv()) begin errors++; $display("FAIL arst_repush obs=%h exp=%h", obs, expv()); end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_rx_threshold();
        test_random();
        test_soft_reset();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
